// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg : shared FSM state type and bus-level constants for the I2C target
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    ADDR_HI,
    ACK_AH,
    ADDR_LO,
    ACK_AL,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  // SDA level reached by the SDA transition (while SCL high) that marks START / STOP
  localparam logic START_SDA = 1'b0;
  localparam logic STOP_SDA  = 1'b1;
  localparam logic ACK_LEVEL = 1'b0;
  localparam logic RW_READ   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync : 2-FF synchronizer plus history FF, reports level and change
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic chg
);

  logic [1:0] sync;
  logic       hist;

  // Preset to 1 so an idle (pulled-up) bus produces no edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      hist <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      hist <= sync[1];
    end
  end

  assign level = sync[1];
  assign chg   = sync[1] ^ hist;

endmodule

`default_nettype wire

// File: rtl/i2c_target_mem.sv
// ---------------------------------------------------------------------------
// i2c_target_mem : I2C target with 16-bit word pointer into an internal byte memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         MEM_AW   = 8,
  parameter int         CLK_FREQ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_valid,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  logic scl_lvl, scl_chg, sda_lvl, sda_chg;

  i2c_line_sync u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl_i),
    .level (scl_lvl),
    .chg   (scl_chg)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda_i),
    .level (sda_lvl),
    .chg   (sda_chg)
  );

  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_lvl && sda_chg && (sda_lvl == START_SDA);
  assign stop_det  = scl_lvl && sda_chg && (sda_lvl == STOP_SDA);
  assign scl_rise  = scl_chg && scl_lvl;
  assign scl_fall  = scl_chg && !scl_lvl;

  i2c_state_e        state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        shreg, shreg_nxt;
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [MEM_AW-1:0] ptr, ptr_nxt;
  logic              rd_mode, rd_mode_nxt;
  logic              sda_oe_nxt, busy_nxt, wr_valid_nxt;
  logic [MEM_AW-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              mem_we;

  logic [7:0] mem [2**MEM_AW];
  logic [7:0] byte_in;
  logic [7:0] rd_shift;
  logic       byte_done;

  assign byte_in   = {shreg, sda_lvl};
  assign byte_done = (bit_cnt == 3'd7);
  assign rd_shift  = mem[ptr] << bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      hi_byte  <= '0;
      ptr      <= '0;
      rd_mode  <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      hi_byte  <= hi_byte_nxt;
      ptr      <= ptr_nxt;
      rd_mode  <= rd_mode_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      wr_valid <= wr_valid_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  // Contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= byte_in;
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    hi_byte_nxt  = hi_byte;
    ptr_nxt      = ptr;
    rd_mode_nxt  = rd_mode;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    mem_we       = 1'b0;

    if (start_det) begin
      state_nxt   = DEVADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        DEVADDR: begin
          shreg_nxt   = byte_in[6:0];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (byte_done) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_nxt   = ACK_DEV;
              busy_nxt    = 1'b1;
              rd_mode_nxt = (byte_in[0] == RW_READ);
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end
          end
        end
        ACK_DEV: state_nxt = rd_mode ? RD_DATA : ADDR_HI;
        ADDR_HI: begin
          shreg_nxt   = byte_in[6:0];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (byte_done) begin
            hi_byte_nxt = byte_in;
            state_nxt   = ACK_AH;
          end
        end
        ACK_AH: state_nxt = ADDR_LO;
        ADDR_LO: begin
          shreg_nxt   = byte_in[6:0];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (byte_done) begin
            ptr_nxt   = MEM_AW'({hi_byte, byte_in});
            state_nxt = ACK_AL;
          end
        end
        ACK_AL: state_nxt = WR_DATA;
        WR_DATA: begin
          shreg_nxt   = byte_in[6:0];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (byte_done) begin
            mem_we       = 1'b1;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = ptr;
            wr_data_nxt  = byte_in;
            ptr_nxt      = ptr + MEM_AW'(1);
            state_nxt    = ACK_WR;
          end
        end
        ACK_WR: state_nxt = WR_DATA;
        RD_DATA: begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (byte_done) begin
            ptr_nxt   = ptr + MEM_AW'(1);
            state_nxt = RD_ACK;
          end
        end
        RD_ACK: begin
          if (sda_lvl == ACK_LEVEL) begin
            state_nxt = RD_DATA;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // SDA ownership only ever changes while SCL is low
      case (state)
        ACK_DEV, ACK_AH, ACK_AL, ACK_WR: sda_oe_nxt = 1'b1;
        RD_DATA:                         sda_oe_nxt = ~rd_shift[7];
        default:                         sda_oe_nxt = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_mem.sv
// Randomized I2C master driving i2c_target_mem, checked against a transaction-level memory model.
`timescale 1ns/1ps

module tb_i2c_target_mem;

  localparam logic [6:0] DEV = 7'h50;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic quiet = 1'b1;
  logic sda_bus;
  logic sda_oe, busy, wr_valid;
  logic [7:0] wr_addr, wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_mem #(
    .DEV_ADDR (DEV),
    .MEM_AW   (8),
    .CLK_FREQ (50_000_000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Behavioural model: byte memory, which bytes are known, and the word pointer
  logic [7:0] model_mem [256];
  bit         model_known [256];
  logic [7:0] model_ptr = 8'h00;
  wr_t        exp_q [$];
  wr_t        seen_q [$];
  wr_t        exp_e;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: SDA must be released whenever the target has no turn,
  // and every committed write must match the next one the model predicted.
  always @(negedge clk) begin
    if (quiet) check("sda_released", {31'b0, sda_oe}, 32'd0);
    if (wr_valid) begin
      seen_q.push_back({wr_addr, wr_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", {24'b0, wr_addr}, {24'b0, exp_e.addr});
        check("wr_data", {24'b0, wr_data}, {24'b0, exp_e.data});
      end
    end
  end

  // ---- bit level master ----
  task automatic bit_out(input logic b);
    sda_m = b; #50; quiet = 1'b1; scl_m = 1'b1; #100; quiet = 1'b0; scl_m = 1'b0; #50;
  endtask

  task automatic byte_out(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
  endtask

  task automatic ack_in(input logic exp_ack, input string name);
    sda_m = 1'b1; #50;
    if (exp_ack) check({name, "_ack_drive"}, {31'b0, sda_oe}, 32'd1);
    else quiet = 1'b1;
    scl_m = 1'b1; #50;
    check({name, "_ack"}, {31'b0, sda_bus}, exp_ack ? 32'd0 : 32'd1);
    #50; scl_m = 1'b0; #50;
  endtask

  task automatic read_byte(output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; quiet = 1'b0; #50; scl_m = 1'b1; #50; got[i] = sda_bus; #50; scl_m = 1'b0; #50;
    end
  endtask

  task automatic start_c();
    quiet = 1'b1; sda_m = 1'b0; #100; scl_m = 1'b0; #50;
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; #50; quiet = 1'b1; scl_m = 1'b1; #50; sda_m = 1'b0; #50; scl_m = 1'b0; #50;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #50; quiet = 1'b1; scl_m = 1'b1; #50; sda_m = 1'b1; #100;
  endtask

  // ---- transaction level, updating the model ----
  task automatic send_hdr(input logic [7:0] b, input logic exp_ack, input string name);
    byte_out(b);
    ack_in(exp_ack, name);
  endtask

  task automatic set_addr(input logic [15:0] a);
    start_c();
    send_hdr({DEV, 1'b0}, 1'b1, "dev_w");
    check("busy_on", {31'b0, busy}, 32'd1);
    send_hdr(a[15:8], 1'b1, "addr_hi");
    send_hdr(a[7:0], 1'b1, "addr_lo");
    model_ptr = a[7:0];
  endtask

  task automatic write_bytes(input byte_q_t d);
    foreach (d[i]) begin
      exp_q.push_back({model_ptr, d[i]});
      send_hdr(d[i], 1'b1, "wr_byte");
      model_mem[model_ptr]   = d[i];
      model_known[model_ptr] = 1'b1;
      model_ptr++;
    end
  endtask

  task automatic read_bytes(input int n, output byte_q_t got);
    logic [7:0] b;
    got = {};
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      got.push_back(b);
      if (model_known[model_ptr]) check("rd_data", {24'b0, b}, {24'b0, model_mem[model_ptr]});
      model_ptr++;
      bit_out(i == n - 1);
    end
    check("busy_after_nack", {31'b0, busy}, 32'd0);
  endtask

  task automatic write_txn(input logic [15:0] a, input byte_q_t d);
    set_addr(a);
    write_bytes(d);
    stop_c();
    check("busy_after_stop", {31'b0, busy}, 32'd0);
  endtask

  task automatic rand_read(input logic [15:0] a, input int n, output byte_q_t got);
    set_addr(a);
    rstart_c();
    send_hdr({DEV, 1'b1}, 1'b1, "dev_r");
    read_bytes(n, got);
    stop_c();
  endtask

  task automatic cur_read(input int n, output byte_q_t got);
    start_c();
    send_hdr({DEV, 1'b1}, 1'b1, "dev_r");
    read_bytes(n, got);
    stop_c();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t d, got;
    logic [7:0] lit_a [3];
    logic [6:0] bad;
    logic [15:0] a;
    int kind;

    #22;
    check("rst_sda_oe",   {31'b0, sda_oe},   32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
    check("rst_wr_addr",  {24'b0, wr_addr},  32'd0);
    check("rst_wr_data",  {24'b0, wr_data},  32'd0);
    #30; rst_n = 1'b1; #100;

    // Sequential write of four bytes at 0x3C
    seen_q = {};
    d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    write_txn(16'h003C, d);
    check("w4_count", seen_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      check("w4_addr", {24'b0, seen_q[i].addr}, 32'h3C + i);
      check("w4_data", {24'b0, seen_q[i].data}, {24'b0, d[i]});
    end

    // Random read back through a repeated START
    rand_read(16'h003C, 4, got);
    check("rr_b0", {24'b0, got[0]}, 32'hDE);
    check("rr_b1", {24'b0, got[1]}, 32'hAD);
    check("rr_b2", {24'b0, got[2]}, 32'hBE);
    check("rr_b3", {24'b0, got[3]}, 32'hEF);

    // Foreign device address
    seen_q = {};
    start_c();
    send_hdr(8'hA2, 1'b0, "dev_a2");
    stop_c();
    check("a2_no_write", seen_q.size(), 32'd0);
    check("a2_busy", {31'b0, busy}, 32'd0);

    // Pointer wrap across 0xFF
    seen_q = {};
    d = {8'h11, 8'h22, 8'h33};
    lit_a = '{8'hFE, 8'hFF, 8'h00};
    write_txn(16'h00FE, d);
    check("wrap_count", seen_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
      check("wrap_addr", {24'b0, seen_q[i].addr}, {24'b0, lit_a[i]});
      check("wrap_data", {24'b0, seen_q[i].data}, {24'b0, d[i]});
    end
    rand_read(16'h00FE, 3, got);
    check("wrap_rd0", {24'b0, got[0]}, 32'h11);
    check("wrap_rd1", {24'b0, got[1]}, 32'h22);
    check("wrap_rd2", {24'b0, got[2]}, 32'h33);

    // Partial byte cut off by STOP
    d = {8'h5A};
    write_txn(16'h0010, d);
    seen_q = {};
    set_addr(16'h0010);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
    stop_c();
    check("part_no_write", seen_q.size(), 32'd0);
    check("part_busy", {31'b0, busy}, 32'd0);
    check("part_sda_oe", {31'b0, sda_oe}, 32'd0);
    cur_read(1, got);
    check("part_cur_rd", {24'b0, got[0]}, 32'h5A);

    // Reset pulsed while the target drives an ACK
    d = {8'hC3};
    write_txn(16'h0020, d);
    set_addr(16'h0020);
    rstart_c();
    byte_out({DEV, 1'b1});
    sda_m = 1'b1; #50;
    check("rst_ack_drive", {31'b0, sda_oe}, 32'd1);
    rst_n = 1'b0; #1;
    check("rst_async_release", {31'b0, sda_oe}, 32'd0);
    check("rst_busy_mid", {31'b0, busy}, 32'd0);
    quiet = 1'b1; #29; rst_n = 1'b1; #20;
    scl_m = 1'b1; #100; scl_m = 1'b0; #50;
    stop_c();
    model_ptr = 8'h00;
    d = {8'h7E};
    write_txn(16'h0021, d);
    rand_read(16'h0020, 2, got);
    check("post_rst_rd0", {24'b0, got[0]}, 32'hC3);
    check("post_rst_rd1", {24'b0, got[1]}, 32'h7E);

    // Randomized traffic around the wrap point
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 4);
      a = {8'($urandom_range(0, 255)), 8'(8'hF8 + 8'($urandom_range(0, 15)))};
      case (kind)
        0: begin
          d = {};
          for (int i = 0; i < $urandom_range(1, 3); i++) d.push_back(8'($urandom_range(0, 255)));
          write_txn(a, d);
        end
        1: rand_read(a, $urandom_range(1, 3), got);
        2: cur_read($urandom_range(1, 3), got);
        3: begin
          bad = 7'($urandom_range(0, 127));
          if (bad == DEV) bad = DEV + 7'd1;
          start_c();
          send_hdr({bad, 1'($urandom_range(0, 1))}, 1'b0, "bad_dev");
          stop_c();
        end
        default: begin
          set_addr(a);
          d = {};
          for (int i = 0; i < $urandom_range(0, 2); i++) d.push_back(8'($urandom_range(0, 255)));
          write_bytes(d);
          for (int i = 0; i < $urandom_range(1, 7); i++) bit_out(1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 0) begin
            stop_c();
          end else begin
            rstart_c();
            send_hdr({DEV, 1'b1}, 1'b1, "dev_r");
            read_bytes(1, got);
            stop_c();
          end
        end
      endcase
    end

    #200;
    check("exp_writes_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
